// File: rtl/bp_me_cache_pkt_arbiter.sv
// ============================================================================
// Module   : bp_me_cache_pkt_arbiter
// Purpose  : Round-robin sharing of one bsg_cache packet port; in-order
//            responses are routed back via a requester-ID tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_me_cache_pkt_arbiter #(
  parameter int num_req_p         = 2,
  parameter int pkt_width_p       = 64,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic [num_req_p*pkt_width_p-1:0]   req_pkt_i,
  input  logic [num_req_p-1:0]               req_v_i,
  output logic [num_req_p-1:0]               req_ready_and_o,

  output logic [pkt_width_p-1:0]             cache_pkt_o,
  output logic                               cache_v_o,
  input  logic                               cache_ready_i,

  input  logic [data_width_p-1:0]            cache_data_i,
  input  logic                               cache_v_i,
  output logic                               cache_yumi_o,

  output logic [data_width_p-1:0]            resp_data_o,
  output logic [num_req_p-1:0]               resp_v_o,
  input  logic [num_req_p-1:0]               resp_yumi_i
);

  localparam int c_LG_REQ = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int c_CNT_W  = (max_outstanding_p + 1 > 1) ? $clog2(max_outstanding_p + 1) : 1;
  localparam int c_PTR_W  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic [c_LG_REQ-1:0] r_rr_ptr;
  logic [c_CNT_W-1:0]  r_outstanding;
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_LG_REQ-1:0] r_tags [max_outstanding_p];

  logic [c_LG_REQ-1:0] w_grant;
  logic [c_LG_REQ-1:0] w_head;
  logic                w_credit;
  logic                w_fifo_empty;
  logic                w_issue;
  logic                w_resp_ok;
  logic                w_pop;

  // Credit comes from registered state only, so a pop at full frees it next cycle.
  assign w_credit     = (r_outstanding != c_CNT_W'(max_outstanding_p));
  assign w_fifo_empty = (r_outstanding == '0);

  always_comb begin
    int  sum;
    logic found;
    sum     = 0;
    found   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < num_req_p; k++) begin
      sum = int'(r_rr_ptr) + k;
      if (sum >= num_req_p) sum = sum - num_req_p;
      if (!found && req_v_i[c_LG_REQ'(sum)]) begin
        found   = 1'b1;
        w_grant = c_LG_REQ'(sum);
      end
    end
  end

  assign cache_v_o   = (|req_v_i) & w_credit & ~reset_i;
  assign cache_pkt_o = req_pkt_i[w_grant*pkt_width_p +: pkt_width_p];
  assign w_issue     = cache_v_o & cache_ready_i;

  always_comb begin
    req_ready_and_o = '0;
    if (w_issue) req_ready_and_o[w_grant] = 1'b1;
  end

  assign w_head       = r_tags[r_rptr];
  assign w_resp_ok    = cache_v_i & ~w_fifo_empty;
  assign w_pop        = w_resp_ok & resp_yumi_i[w_head];
  assign cache_yumi_o = w_pop;
  assign resp_data_o  = cache_data_i;

  always_comb begin
    resp_v_o = '0;
    if (w_resp_ok) resp_v_o[w_head] = 1'b1;
  end

  // Tag storage needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk_i) begin
    if (w_issue) r_tags[r_wptr] <= w_grant;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      if (w_issue) begin
        r_rr_ptr <= (w_grant == c_LG_REQ'(num_req_p - 1)) ? '0 : w_grant + 1'b1;
        r_wptr   <= (r_wptr == c_PTR_W'(max_outstanding_p - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_W'(max_outstanding_p - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && cache_v_i && w_fifo_empty)
      $error("bp_me_cache_pkt_arbiter: cache response with no request outstanding");
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// ============================================================================
// Module   : tb_bp_me_cache_pkt_arbiter
// Purpose  : Scoreboard bench for bp_me_cache_pkt_arbiter (2 requesters, 4 credits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_me_cache_pkt_arbiter;

  localparam int c_N   = 2;
  localparam int c_PW  = 16;
  localparam int c_DW  = 16;
  localparam int c_MAX = 4;

  logic                  clk_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic [c_N*c_PW-1:0]   req_pkt_i;
  logic [c_N-1:0]        req_v_i = '0;
  logic [c_N-1:0]        req_ready_and_o;
  logic [c_PW-1:0]       cache_pkt_o;
  logic                  cache_v_o;
  logic                  cache_ready_i = 1'b0;
  logic [c_DW-1:0]       cache_data_i = '0;
  logic                  cache_v_i = 1'b0;
  logic                  cache_yumi_o;
  logic [c_DW-1:0]       resp_data_o;
  logic [c_N-1:0]        resp_v_o;
  logic [c_N-1:0]        resp_yumi_i;
  logic [c_N-1:0]        yumi_en = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_issue_q[$];
  int exp_resp_q[$];

  bp_me_cache_pkt_arbiter #(
    .num_req_p(c_N), .pkt_width_p(c_PW), .data_width_p(c_DW), .max_outstanding_p(c_MAX)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_ready_and_o(req_ready_and_o),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_ready_i(cache_ready_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // Fixed per-requester packets expose a wrong slice selection.
  assign req_pkt_i   = {16'h2222, 16'h1111};
  assign resp_yumi_i = resp_v_o & yumi_en;

  function automatic logic [31:0] pkt_of(int id);
    return (id == 0) ? 32'h1111 : 32'h2222;
  endfunction

  function automatic logic [31:0] onehot(int id);
    return 32'd1 << id;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (cache_v_i) begin
        if (exp_resp_q.size() == 0) begin
          chk("spurious_resp_v", 32'(resp_v_o), 32'd0);
          chk("spurious_yumi", 32'(cache_yumi_o), 32'd0);
        end else begin
          int h;
          h = exp_resp_q[0];
          chk("resp_route", 32'(resp_v_o), onehot(h));
          chk("resp_data", 32'(resp_data_o), 32'(cache_data_i));
          chk("cache_yumi", 32'(cache_yumi_o), 32'(yumi_en[h]));
          if (yumi_en[h]) void'(exp_resp_q.pop_front());
        end
      end else begin
        chk("idle_resp_v", 32'(resp_v_o), 32'd0);
      end
      if (cache_v_o && cache_ready_i) begin
        if (exp_issue_q.size() == 0) begin
          chk("unexpected_issue", 32'(req_ready_and_o), 32'd0);
        end else begin
          int e;
          e = exp_issue_q.pop_front();
          chk("grant", 32'(req_ready_and_o), onehot(e));
          chk("issue_pkt", 32'(cache_pkt_o), pkt_of(e));
          exp_resp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #2;
    req_v_i = 2'b11;
    #1;
    chk("rst_cache_v", 32'(cache_v_o), 32'd0);
    chk("rst_ready", 32'(req_ready_and_o), 32'd0);
    chk("rst_resp_v", 32'(resp_v_o), 32'd0);
    chk("rst_yumi", 32'(cache_yumi_o), 32'd0);
    req_v_i = '0;
    step();
    reset_i = 1'b0;

    // Round robin: both requesters valid, grants alternate from 0.
    exp_issue_q = '{0, 1, 0, 1};
    cache_ready_i = 1'b1;
    req_v_i = 2'b11;
    repeat (4) step();
    req_v_i = '0;
    chk("rr_all_issued", 32'(exp_issue_q.size()), 32'd0);
    yumi_en = 2'b11;
    cache_v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cache_data_i = 16'hD000 + 16'(k);
      step();
    end
    cache_v_i = 1'b0;
    chk("rr_drained", 32'(dut.r_outstanding), 32'd0);

    // Credit limit: requester 1 alone gets exactly 4 issues.
    exp_issue_q = '{1, 1, 1, 1};
    req_v_i = 2'b10;
    repeat (6) step();
    chk("credit_stop", 32'(cache_v_o), 32'd0);
    chk("credit_full", 32'(dut.r_outstanding), 32'd4);
    chk("credit_issued", 32'(exp_issue_q.size()), 32'd0);

    // Pop while full: no issue this cycle, one issue next cycle.
    exp_issue_q.push_back(1);
    cache_data_i = 16'hE000;
    cache_v_i = 1'b1;
    #1;
    chk("full_pop_no_issue", 32'(cache_v_o), 32'd0);
    @(posedge clk_i);
    #1;
    cache_v_i = 1'b0;
    chk("full_pop_cnt", 32'(dut.r_outstanding), 32'd3);
    chk("freed_credit_v", 32'(cache_v_o), 32'd1);
    step();
    chk("refill_cnt", 32'(dut.r_outstanding), 32'd4);
    chk("refill_stop", 32'(cache_v_o), 32'd0);
    req_v_i = '0;

    // Drain two, then issue and pop together.
    cache_v_i = 1'b1;
    cache_data_i = 16'hE001;
    step();
    cache_data_i = 16'hE002;
    step();
    exp_issue_q.push_back(0);
    req_v_i = 2'b01;
    cache_data_i = 16'hE003;
    step();
    req_v_i = '0;
    chk("simul_cnt", 32'(dut.r_outstanding), 32'd2);

    // Backpressure on head=1, then release and route to next ID 0.
    yumi_en = 2'b00;
    cache_data_i = 16'hE004;
    repeat (3) step();
    chk("bp_yumi", 32'(cache_yumi_o), 32'd0);
    chk("bp_cnt", 32'(dut.r_outstanding), 32'd2);
    yumi_en = 2'b10;
    step();
    yumi_en = 2'b11;
    cache_data_i = 16'hE005;
    step();
    cache_v_i = 1'b0;
    chk("bp_drained", 32'(dut.r_outstanding), 32'd0);

    // Spurious response, kept between clock edges.
    cache_data_i = 16'hF000;
    cache_v_i = 1'b1;
    #1;
    chk("spur_resp_v", 32'(resp_v_o), 32'd0);
    chk("spur_yumi", 32'(cache_yumi_o), 32'd0);
    @(negedge clk_i);
    #1;
    cache_v_i = 1'b0;
    step();

    // Mid-traffic asynchronous reset.
    exp_issue_q.push_back(1);
    req_v_i = 2'b11;
    step();
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_cache_v", 32'(cache_v_o), 32'd0);
    chk("mid_rst_ready", 32'(req_ready_and_o), 32'd0);
    chk("mid_rst_resp_v", 32'(resp_v_o), 32'd0);
    chk("mid_rst_cnt", 32'(dut.r_outstanding), 32'd0);
    chk("mid_rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    exp_resp_q.delete();
    step();
    exp_issue_q.push_back(0);
    reset_i = 1'b0;
    step();
    req_v_i = '0;
    step();
    chk("post_rst_issued", 32'(exp_issue_q.size()), 32'd0);
    chk("post_rst_cnt", 32'(dut.r_outstanding), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
